merge: RTL and testbench



---
 rtl/merge.sv | 101 ++++++++++
 tb/tb_merge.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/merge.sv
// Round-robin N-to-1 bus merge: one granted master owns the shared slave port
// until the slave answers ready or the master withdraws its valid.

module merge_lane #(
  parameter int REQ_W  = 69,
  parameter int RESP_W = 33
) (
  input  logic [REQ_W-1:0]  req,
  input  logic              sel,
  input  logic [RESP_W-1:0] s_resp,
  output logic              valid,
  output logic [REQ_W-1:0]  req_gated,
  output logic [RESP_W-1:0] resp
);
  assign valid     = req[REQ_W-1];
  assign req_gated = sel ? req : '0;
  assign resp      = sel ? s_resp : '0;
endmodule

module merge #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int REQ_W     = 1 + ADDR_W + DATA_W + DATA_W/8,
  parameter int RESP_W    = DATA_W + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS*REQ_W-1:0]    m_req,
  output logic [N_MASTERS*RESP_W-1:0]   m_resp,
  output logic [REQ_W-1:0]              s_req,
  input  logic [RESP_W-1:0]             s_resp
);
  localparam int GW = $clog2(N_MASTERS);
  localparam int IW = GW + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                            state;
  logic [GW-1:0]                     grant;
  logic [GW-1:0]                     ptr;
  logic [N_MASTERS-1:0]              m_valid;
  logic [N_MASTERS-1:0]              sel;
  logic [N_MASTERS-1:0][REQ_W-1:0]   req_g;
  logic [GW-1:0]                     win;
  logic [IW-1:0]                     idx;

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_lane
    assign sel[i] = (state == BUSY) && (grant == GW'(i));
    merge_lane #(.REQ_W(REQ_W), .RESP_W(RESP_W)) u_lane (
      .req       (m_req[i*REQ_W +: REQ_W]),
      .sel       (sel[i]),
      .s_resp    (s_resp),
      .valid     (m_valid[i]),
      .req_gated (req_g[i]),
      .resp      (m_resp[i*RESP_W +: RESP_W])
    );
  end

  // Only the granted lane contributes, so an OR is the slave-side mux.
  always_comb begin
    s_req = '0;
    for (int i = 0; i < N_MASTERS; i++) s_req = s_req | req_g[i];
  end

  // Scan from the far end back to ptr so the last hit is the first valid at/after ptr.
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = N_MASTERS-1; k >= 0; k--) begin
      idx = {1'b0, ptr} + IW'(k);
      if (idx >= IW'(N_MASTERS)) idx = idx - IW'(N_MASTERS);
      if (m_valid[idx[GW-1:0]]) win = idx[GW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: if (|m_valid) begin
          grant <= win;
          state <= BUSY;
        end
        BUSY: begin
          // Ready wins over a simultaneous valid drop: that is a completion.
          if (s_resp[0]) begin
            state <= IDLE;
            ptr   <= (grant == GW'(N_MASTERS-1)) ? '0 : grant + GW'(1);
          end else if (!m_valid[grant]) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_merge.sv
// Directed bench for merge (3 masters): scoreboard of expected responses,
// popped by a negedge monitor whenever any master sees ready.

module tb_merge;
  localparam int N      = 3;
  localparam int REQ_W  = 69;
  localparam int RESP_W = 33;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0][REQ_W-1:0]  mreq;
  logic [N-1:0][RESP_W-1:0] mresp;
  logic [REQ_W-1:0]         sreq;
  logic [RESP_W-1:0]        sresp;

  typedef struct {
    int               m;
    logic [REQ_W-1:0] sreq;
    logic [31:0]      rdata;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  merge #(.N_MASTERS(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .m_req (mreq),
    .m_resp(mresp),
    .s_req (sreq),
    .s_resp(sresp)
  );

  always #5 clk = ~clk;

  function automatic logic [REQ_W-1:0] mk(logic v, logic [31:0] a, logic [31:0] d, logic [3:0] s);
    return {v, a, d, s};
  endfunction

  task automatic chk(string nm, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    tick();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic respond(int m, logic [REQ_W-1:0] r, logic [31:0] d);
    exp_t e;
    e.m = m; e.sreq = r; e.rdata = d;
    sb.push_back(e);
    sresp = {d, 1'b1};
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [N-1:0][RESP_W-1:0] er;
    if (!rst && (mresp[0][0] || mresp[1][0] || mresp[2][0])) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp got %h exp none", mresp);
      end else begin
        e = sb.pop_front();
        er = '0;
        er[e.m] = {e.rdata, 1'b1};
        if (mresp !== er || sreq !== e.sreq) begin
          errors++;
          $display("FAIL resp_m%0d got %h/%h exp %h/%h", e.m, mresp, sreq, er, e.sreq);
        end
      end
    end
  end

  logic [REQ_W-1:0] r [N];

  initial begin
    r[0] = mk(1'b1, 32'h0000_1000, 32'h1111_1111, 4'hF);
    r[1] = mk(1'b1, 32'h0000_2000, 32'h2222_2222, 4'h3);
    r[2] = mk(1'b1, 32'h0000_3000, 32'h3333_3333, 4'hC);
    sresp = '0;
    for (int i = 0; i < N; i++) mreq[i] = r[i];

    // Reset held with all valids high
    repeat (3) begin
      @(negedge clk);
      chk("rst_sreq", sreq, 0);
      chk("rst_mresp", mresp, 0);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); chk("post_rst_idle", sreq, 0);
    tick();
    respond(0, r[0], 32'h1111_0000);
    @(negedge clk);
    chk("first_grant_sreq", sreq, r[0]);
    chk("first_grant_idx", dut.grant, 0);
    tick();
    sresp = '0;
    mreq = '0;
    chk("ptr_after_m0", dut.ptr, 1);

    // Round-robin, slave always ready
    pulse_rst();
    for (int i = 0; i < N; i++) mreq[i] = r[i];
    sresp = {32'hA5A5_0000, 1'b1};
    for (int k = 0; k < 6; k++) begin
      tick();
      respond(k % N, r[k % N], 32'hA5A5_0000);
      @(negedge clk); chk($sformatf("rr_sreq%0d", k), sreq, r[k % N]);
      tick();
      @(negedge clk); chk($sformatf("rr_bubble%0d", k), sreq, 0);
    end
    mreq = '0;
    sresp = '0;

    // Single master read (master 2 exercises pointer wrap)
    pulse_rst();
    mreq[2] = mk(1'b1, 32'h40, 32'h0, 4'h0);
    tick();
    @(negedge clk);
    chk("single_sreq", sreq, mk(1'b1, 32'h40, 32'h0, 4'h0));
    chk("single_wait1", mresp, 0);
    tick();
    @(negedge clk); chk("single_wait2", mresp, 0);
    tick();
    respond(2, mk(1'b1, 32'h40, 32'h0, 4'h0), 32'hDEAD_BEEF);
    @(negedge clk); chk("single_m0_zero", mresp[0], 0);
    tick();
    mreq = '0;
    sresp = '0;
    chk("single_ptr_wrap", dut.ptr, 0);

    // Lock: master 1 arrives while master 0 holds the grant
    pulse_rst();
    mreq[0] = r[0];
    tick();
    mreq[1] = r[1];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); chk($sformatf("lock_c%0d", c), sreq, r[0]);
      tick();
    end
    respond(0, r[0], 32'hCAFE_0000);
    @(negedge clk);
    tick();
    mreq[0] = '0;
    sresp = '0;
    @(negedge clk); chk("lock_bubble", sreq, 0);
    tick();
    respond(1, r[1], 32'hBEEF_0001);
    @(negedge clk);
    chk("lock_next_sreq", sreq, r[1]);
    chk("lock_next_grant", dut.grant, 1);
    tick();
    mreq = '0;
    sresp = '0;

    // Abort: master 1 drops valid with no ready; ptr must stay at 1
    pulse_rst();
    mreq[0] = r[0];
    tick();
    respond(0, r[0], 32'h0000_0AB0);
    @(negedge clk);
    tick();
    mreq[0] = '0;
    sresp = '0;
    mreq[1] = r[1];
    tick();
    chk("abort_grant", dut.grant, 1);
    mreq[1] = mk(1'b0, 32'h0000_2000, 32'h2222_2222, 4'h3);
    @(negedge clk);
    chk("abort_sreq_valid", sreq[REQ_W-1], 0);
    chk("abort_mresp", mresp, 0);
    tick();
    chk("abort_ptr", dut.ptr, 1);
    @(negedge clk);
    chk("abort_idle", sreq, 0);
    mreq[0] = r[0];
    mreq[1] = r[1];
    tick();
    chk("abort_regrant", dut.grant, 1);
    @(negedge clk); chk("abort_regrant_sreq", sreq, r[1]);
    mreq = '0;

    // Async reset between edges mid-transaction
    tick();
    mreq[0] = r[0];
    tick();
    #1 chk("async_pre", sreq, r[0]);
    rst = 1'b1;
    #1;
    chk("async_sreq", sreq, 0);
    chk("async_mresp", mresp, 0);
    rst = 1'b0;
    mreq = '0;
    sresp = {32'h7777_7777, 1'b1};
    @(negedge clk); chk("async_ready_ignored", mresp, 0);
    tick();
    sresp = '0;
    chk("async_ptr", dut.ptr, 0);
    @(negedge clk); chk("async_idle", sreq, 0);

    repeat (2) tick();
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
